// File: rtl/mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_mp
// Purpose  : Parametrised multi-read-port MIPS register file. Three write
//            sources (ALU > load/store > PC-link) are arbitrated with fixed
//            priority. Requests that lose arbitration are tallied in a
//            saturating 8-bit drop counter. Storage is cleared by a
//            sequential sweep after reset, so the array can map to RAM.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            rd_addr/rd_data   - NUM_READ packed combinational read ports
//            wr_alu_*          - ALU write-back (full word)
//            wr_ld_*           - load write-back with byte enables
//            wr_pc_*           - PC write-back; link=1 forces LINK_REG
//            busy              - high while the clear sweep runs
//            drop_count        - saturating count of lost write requests
//            v0                - array contents of V0_REG (never bypassed)
// Config   : define REGFILE_BYPASS_EN to forward the winning write to any
//            read port addressing the same register in the write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int LINK_REG = 31,
  parameter int V0_REG   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  input  logic                         wr_alu_en,
  input  logic [ADDR_W-1:0]            wr_alu_addr,
  input  logic [DATA_W-1:0]            wr_alu_data,
  input  logic                         wr_ld_en,
  input  logic [ADDR_W-1:0]            wr_ld_addr,
  input  logic [DATA_W-1:0]            wr_ld_data,
  input  logic [DATA_W/8-1:0]          wr_ld_be,
  input  logic                         wr_pc_en,
  input  logic                         wr_pc_link,
  input  logic [ADDR_W-1:0]            wr_pc_addr,
  input  logic [DATA_W-1:0]            wr_pc_data,
  output logic                         busy,
  output logic [7:0]                   drop_count,
  output logic [DATA_W-1:0]            v0
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam int              NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] V0_ADDR   = ADDR_W'(V0_REG);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   sweep_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Arbitrated write request
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NBYTES-1:0]   wr_mask;
  logic                wr_commit;
  logic                ready_act;

  logic [1:0]          n_req;
  logic [1:0]          n_drop;
  logic [8:0]          drop_sum;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && sweep_idx == LAST_IDX) begin
      state_next = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= '0;
    end else if (state == CLEAR) begin
      sweep_idx <= sweep_idx + ADDR_W'(1);
    end
  end

  assign busy      = (state == CLEAR);
  assign ready_act = (state == READY) && !rst;

  // --------------------------------------------------------------------------
  // Write arbitration: ALU > LD > PC
  // --------------------------------------------------------------------------
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    if (wr_alu_en) begin
      wr_valid = 1'b1;
      wr_addr  = wr_alu_addr;
      wr_data  = wr_alu_data;
      wr_mask  = '1;
    end else if (wr_ld_en) begin
      // An all-zero byte enable still wins; it simply writes nothing.
      wr_valid = 1'b1;
      wr_addr  = wr_ld_addr;
      wr_data  = wr_ld_data;
      wr_mask  = wr_ld_be;
    end else if (wr_pc_en) begin
      wr_valid = 1'b1;
      wr_addr  = wr_pc_link ? LINK_ADDR : wr_pc_addr;
      wr_data  = wr_pc_data;
      wr_mask  = '1;
    end
  end

  // Register 0 is hardwired: the winner is consumed but nothing is stored.
  assign wr_commit = ready_act && wr_valid && (wr_addr != '0);

  // --------------------------------------------------------------------------
  // Drop counter: every asserted enable except the winner is a drop.
  // --------------------------------------------------------------------------
  assign n_req    = {1'b0, wr_alu_en} + {1'b0, wr_ld_en} + {1'b0, wr_pc_en};
  assign n_drop   = (n_req == 2'd0) ? 2'd0 : (n_req - 2'd1);
  assign drop_sum = {1'b0, drop_count} + 9'(n_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (state == READY) begin
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Storage: no reset on the array itself; the sweep clears it instead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[sweep_idx] <= '0;
      end else if (wr_commit) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_mask[b]) begin
            mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] arr_val;
    logic [DATA_W-1:0] port_val;

    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign arr_val = mem[addr];

`ifdef REGFILE_BYPASS_EN
    // Merge enabled bytes of the in-flight write over the stored word.
    always_comb begin
      port_val = arr_val;
      if (wr_commit && (wr_addr == addr)) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_mask[b]) begin
            port_val[b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
`else
    assign port_val = arr_val;
`endif

    assign rd_data[p*DATA_W +: DATA_W] =
      ((state == CLEAR) || (addr == '0)) ? '0 : port_val;
  end

  assign v0 = (state == CLEAR) ? '0 : mem[V0_ADDR];

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_mp
// Purpose  : Self-checking bench for mips_regfile_mp (default parameters).
//            Directed scenarios plus randomized traffic, all compared
//            against a behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_mp;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_alu_en;
  logic [4:0]  wr_alu_addr;
  logic [31:0] wr_alu_data;
  logic        wr_ld_en;
  logic [4:0]  wr_ld_addr;
  logic [31:0] wr_ld_data;
  logic [3:0]  wr_ld_be;
  logic        wr_pc_en;
  logic        wr_pc_link;
  logic [4:0]  wr_pc_addr;
  logic [31:0] wr_pc_data;
  logic        busy;
  logic [7:0]  drop_count;
  logic [31:0] v0;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_clear;
  int          mdl_left;
  int          mdl_drop;

  always #5 clk = ~clk;

  mips_regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_alu_en   (wr_alu_en),
    .wr_alu_addr (wr_alu_addr),
    .wr_alu_data (wr_alu_data),
    .wr_ld_en    (wr_ld_en),
    .wr_ld_addr  (wr_ld_addr),
    .wr_ld_data  (wr_ld_data),
    .wr_ld_be    (wr_ld_be),
    .wr_pc_en    (wr_pc_en),
    .wr_pc_link  (wr_pc_link),
    .wr_pc_addr  (wr_pc_addr),
    .wr_pc_data  (wr_pc_data),
    .busy        (busy),
    .drop_count  (drop_count),
    .v0          (v0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  // Which request wins this cycle, as the priority rule states it.
  task automatic pick(output bit v, output logic [4:0] a, output logic [3:0] m,
                      output logic [31:0] d);
    v = 1'b1;
    if (wr_alu_en) begin
      a = wr_alu_addr; m = 4'hF; d = wr_alu_data;
    end else if (wr_ld_en) begin
      a = wr_ld_addr; m = wr_ld_be; d = wr_ld_data;
    end else if (wr_pc_en) begin
      a = wr_pc_link ? 5'd31 : wr_pc_addr; m = 4'hF; d = wr_pc_data;
    end else begin
      v = 1'b0; a = 5'd0; m = 4'h0; d = 32'h0;
    end
  endtask

  task automatic compare_outputs();
    bit          v;
    logic [4:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [4:0]  a;
    logic [31:0] e;
    pick(v, wa, wm, wd);
    check_eq("busy", {31'b0, busy}, {31'b0, mdl_clear});
    check_eq("drop_count", {24'b0, drop_count}, mdl_drop);
    check_eq("v0", v0, mdl_clear ? 32'h0 : mdl_mem[2]);
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      e = (mdl_clear || a == 5'd0) ? 32'h0 : mdl_mem[a];
`ifdef REGFILE_BYPASS_EN
      if (!mdl_clear && !rst && v && wa == a && wa != 5'd0) e = merge(e, wd, wm);
`endif
      check_eq(p == 0 ? "rd_port0" : "rd_port1", rd_data[p*32 +: 32], e);
    end
  endtask

  // Apply the rising edge to the model.
  task automatic model_edge();
    bit          v;
    logic [4:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    int          n;
    if (rst) begin
      mdl_clear = 1'b1;
      mdl_left  = DEPTH;
      mdl_drop  = 0;
    end else if (mdl_clear) begin
      mdl_left--;
      if (mdl_left == 0) begin
        mdl_clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
      end
    end else begin
      pick(v, wa, wm, wd);
      n = int'(wr_alu_en) + int'(wr_ld_en) + int'(wr_pc_en);
      if (n > 1) mdl_drop = (mdl_drop + n - 1 > 255) ? 255 : mdl_drop + n - 1;
      if (v && wa != 5'd0) mdl_mem[wa] = merge(mdl_mem[wa], wd, wm);
    end
  endtask

  // Inputs are set by the caller just after a rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_alu_en = 1'b0; wr_ld_en = 1'b0; wr_pc_en = 1'b0;
    wr_pc_link = 1'b0; wr_ld_be = 4'h0;
  endtask

  task automatic rand_inputs(input bit en_ok);
    rd_addr     = 10'($urandom);
    wr_alu_en   = en_ok && ($urandom_range(0, 2) == 0);
    wr_alu_addr = 5'($urandom);
    wr_alu_data = $urandom;
    wr_ld_en    = en_ok && ($urandom_range(0, 2) == 0);
    wr_ld_addr  = 5'($urandom);
    wr_ld_data  = $urandom;
    wr_ld_be    = 4'($urandom);
    wr_pc_en    = en_ok && ($urandom_range(0, 2) == 0);
    wr_pc_link  = 1'($urandom);
    wr_pc_addr  = 5'($urandom);
    wr_pc_data  = $urandom;
  endtask

  task automatic alu_wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    wr_alu_en = 1'b1; wr_alu_addr = a; wr_alu_data = d;
    cycle();
  endtask

  task automatic peek(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1);
    idle();
    rd_addr = {a1, a0};
    #2;
    check_eq({tag, "_p0"}, rd_data[31:0], e0);
    check_eq({tag, "_p1"}, rd_data[63:32], e1);
    cycle();
  endtask

  // Count busy cycles after release, with write traffic that must be ignored.
  task automatic sweep_wait(input string tag, input int exp_cycles);
    int n;
    n = 0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) break;
      n++;
      rand_inputs(1'b1);
      cycle();
    end
    idle();
    check_eq(tag, n, exp_cycles);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rd_addr = '0;
    wr_alu_addr = '0; wr_alu_data = '0; wr_ld_addr = '0; wr_ld_data = '0;
    wr_pc_addr = '0; wr_pc_data = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'hDEAD_0000 + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    mdl_clear = 1'b1; mdl_left = DEPTH; mdl_drop = 0;

    // Reset values while rst is still high
    rd_addr = {5'd7, 5'd2};
    #1;
    check_eq("reset_busy", {31'b0, busy}, 32'd1);
    check_eq("reset_drop", {24'b0, drop_count}, 32'd0);
    check_eq("reset_v0", v0, 32'h0);
    check_eq("reset_rd", rd_data[63:32], 32'h0);
    cycle();

    // Sweep length with ignored writes, then every entry reads zero
    sweep_wait("sweep_busy_cycles", DEPTH);
    check_eq("sweep_drop_zero", {24'b0, drop_count}, 32'd0);
    for (int a = 0; a < DEPTH; a += 2) peek("sweep_zero", 5'(a), 5'(a + 1), 32'h0, 32'h0);

    // Priority and drop saturation
    alu_wr(5'd6, 32'h0000_0066);
    alu_wr(5'd7, 32'h0000_0077);
    idle();
    wr_alu_en = 1'b1; wr_alu_addr = 5'd5; wr_alu_data = 32'h1111_1111;
    wr_ld_en  = 1'b1; wr_ld_addr  = 5'd6; wr_ld_data  = 32'hFFFF_FFFF; wr_ld_be = 4'hF;
    wr_pc_en  = 1'b1; wr_pc_addr  = 5'd7; wr_pc_data  = 32'hFFFF_FFFF;
    cycle();
    check_eq("prio_drop2", {24'b0, drop_count}, 32'd2);
    peek("prio_r5_r6", 5'd5, 5'd6, 32'h1111_1111, 32'h0000_0066);
    peek("prio_r7", 5'd7, 5'd0, 32'h0000_0077, 32'h0);
    wr_alu_en = 1'b1; wr_ld_en = 1'b1; wr_pc_en = 1'b1; wr_ld_be = 4'hF;
    repeat (200) cycle();
    check_eq("drop_saturate", {24'b0, drop_count}, 32'd255);

    // Byte enables
    alu_wr(5'd9, 32'hAABB_CCDD);
    idle();
    wr_ld_en = 1'b1; wr_ld_addr = 5'd9; wr_ld_data = 32'h1122_3344; wr_ld_be = 4'b0101;
    cycle();
    peek("be_0101", 5'd9, 5'd0, 32'hAA22_CC44, 32'h0);
    idle();
    wr_ld_en = 1'b1; wr_ld_addr = 5'd9; wr_ld_data = 32'h0; wr_ld_be = 4'b0000;
    cycle();
    peek("be_0000", 5'd9, 5'd0, 32'hAA22_CC44, 32'h0);

    // Link and register zero
    alu_wr(5'd4, 32'h4444_4444);
    idle();
    wr_pc_en = 1'b1; wr_pc_link = 1'b1; wr_pc_addr = 5'd4; wr_pc_data = 32'h0040_0008;
    cycle();
    peek("link", 5'd31, 5'd4, 32'h0040_0008, 32'h4444_4444);
    alu_wr(5'd0, 32'hFFFF_FFFF);
    peek("zero", 5'd0, 5'd31, 32'h0, 32'h0040_0008);

    // Same-cycle read of the register being written; v0 never bypassed
    alu_wr(5'd3, 32'h0);
    idle();
    wr_alu_en = 1'b1; wr_alu_addr = 5'd3; wr_alu_data = 32'hDEAD_BEEF;
    rd_addr = {5'd3, 5'd0};
    #2;
`ifdef REGFILE_BYPASS_EN
    check_eq("bypass_port1", rd_data[63:32], 32'hDEAD_BEEF);
`else
    check_eq("bypass_port1", rd_data[63:32], 32'h0);
`endif
    cycle();
    idle();
    wr_alu_en = 1'b1; wr_alu_addr = 5'd2; wr_alu_data = 32'h5;
    #2;
    check_eq("v0_same_cycle", v0, 32'h0);
    cycle();
    idle();
    #2;
    check_eq("v0_next_cycle", v0, 32'h5);
    cycle();

    // Reset in the middle of the sweep restarts it
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    sweep_wait("midsweep_busy_cycles", DEPTH);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1'b1);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-read-port register file for the MIPS core. It generalises the CPU register file to DATA_W/ADDR_W/NUM_READ, honours arbitrary byte-enable patterns, and arbitrates three write sources (ALU, load/store, PC-link) with a fixed priority and a saturating drop counter. It clears its storage with a sequential post-reset sweep so the array can map to RAM. It sits between decode (read addresses), and ALU/load-store/PC (write-back).

## Interface
- DATA_W, 32, register width; multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_READ, 2, number of combinational read ports
- LINK_REG, 31, destination used by PC writes with link set
- V0_REG, 2, register exposed on v0
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_READ*DATA_W  read data; port p at [p*DATA_W +: DATA_W]
- wr_alu_en / wr_alu_addr / wr_alu_data  in  1 / ADDR_W / DATA_W  ALU write-back, full word
- wr_ld_en / wr_ld_addr / wr_ld_data / wr_ld_be  in  1 / ADDR_W / DATA_W / DATA_W/8  load write-back with byte enables
- wr_pc_en / wr_pc_link / wr_pc_addr / wr_pc_data  in  1 / 1 / ADDR_W / DATA_W  link write; link=1 forces LINK_REG
- busy  out  1  high while the clear sweep runs
- drop_count  out  8  saturating count of write requests lost to arbitration
- v0  out  DATA_W  contents of V0_REG (array value, never bypassed)

## Operation
- States: CLEAR, READY. rst=1 forces CLEAR, sweep index 0, drop_count 0; no array write while rst is high.
- CLEAR (rst=0): each cycle writes 0 to entry index, index increments; after writing entry DEPTH-1, next state READY. busy=1 in CLEAR.
- rst reasserted mid-sweep or in READY: back to CLEAR, index 0, full sweep restarts.
- In CLEAR: all rd_data = 0, v0 = 0, all write requests ignored and not counted.
- READY, write select: ALU > LD > PC. Winner commits at the edge; each other asserted enable is a dropped request.
- drop_count += number of dropped requests that cycle (0–2), saturating at 255; held until rst.
- ALU and PC writes: all bytes. LD write: byte i written iff wr_ld_be[i]; any pattern legal, including non-contiguous; be=0 means no write (still wins arbitration, still counted as winner).
- Writes to address 0 discarded; register 0 always reads 0. A discarded address-0 winner still causes lower sources to count as dropped.
- Read ports: asynchronous, index array by rd_addr; address 0 returns 0.

## Timing
- Reset values: busy=1, drop_count=0, rd_data=0, v0=0.
- busy stays high for exactly DEPTH cycles after the first edge with rst=0; READY from edge DEPTH onward.
- Write latency: 1 edge; without bypass, reads see the new value the cycle after the commit edge.
- Read-to-read: 0 cycles (combinational).
- Simultaneous write and read to same address: governed by REGFILE_BYPASS_EN.

## Configuration
- REGFILE_BYPASS_EN defined: each read port whose address matches the winning write address (nonzero, READY) returns the merged value in the same cycle: new bytes where enabled, old bytes elsewhere. v0 unaffected.
- Not defined: read ports return the pre-write array value during the write cycle.

## Test plan
- Reset sweep, DEPTH=32: pulse rst 2 cycles, preload irrelevant -> busy high exactly 32 cycles after release, all 32 entries then read 0; write request during sweep leaves drop_count=0 and no entry changed.
- Priority: same cycle ALU r5=0x11111111, LD r6, PC r7 -> r5=0x11111111, r6/r7 unchanged, drop_count=2; repeat 200 times -> drop_count saturates at 255.
- Byte enables: r9=0xAABBCCDD, LD be=4'b0101 data 0x11223344 -> r9=0xAA22CC44; be=0 -> r9 unchanged.
- Link and zero: PC link=1 addr=4 data 0x00400008 -> r31=0x00400008, r4 unchanged; ALU write r0=0xFFFFFFFF -> r0 reads 0.
- Bypass: r3=0x0, ALU write r3=0xDEADBEEF with rd_addr port1=3 same cycle -> with REGFILE_BYPASS_EN port1=0xDEADBEEF, without port1=0x00000000; v0 after write to r2=0x5 reads 0x5 next cycle.
- Reset mid-sweep: assert rst at sweep index 10 -> busy remains high 32 further cycles after release.
